// File: rtl/dcache_refill_responder.sv
// AXI4 subordinate backing the data cache: serves INCR refill reads and
// writeback writes from a word-addressed on-chip memory, one burst at a time.
module dcache_refill_responder #(
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int unsigned NUM_WORDS = 1024,
  parameter int unsigned ID_WIDTH  = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                aw_valid_i,
  output logic                aw_ready_o,
  input  logic [63:0]         aw_addr_i,
  input  logic [7:0]          aw_len_i,
  input  logic [ID_WIDTH-1:0] aw_id_i,
  input  logic                w_valid_i,
  output logic                w_ready_o,
  input  logic [63:0]         w_data_i,
  input  logic [7:0]          w_strb_i,
  input  logic                w_last_i,
  output logic                b_valid_o,
  input  logic                b_ready_i,
  output logic [1:0]          b_resp_o,
  output logic [ID_WIDTH-1:0] b_id_o,
  input  logic                ar_valid_i,
  output logic                ar_ready_o,
  input  logic [63:0]         ar_addr_i,
  input  logic [7:0]          ar_len_i,
  input  logic [ID_WIDTH-1:0] ar_id_i,
  output logic                r_valid_o,
  input  logic                r_ready_i,
  output logic [63:0]         r_data_o,
  output logic [1:0]          r_resp_o,
  output logic                r_last_o,
  output logic [ID_WIDTH-1:0] r_id_o
);

  localparam int unsigned IDX_W = $clog2(NUM_WORDS);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, READ, WDATA, WRESP} state_e;

  state_e                state_q, state_d;
  logic [63:0]           addr_q;
  logic [7:0]            len_q;
  logic [7:0]            beat_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic                  err_q;

  logic [63:0]           mem [NUM_WORDS];

  logic [63:0]           offset;
  logic [63:0]           word_off;
  logic                  in_range;
  logic [IDX_W-1:0]      idx;
  logic                  last_beat;
  logic                  aw_hs, ar_hs, w_hs, r_hs;

  // Address decode of the current beat; a below-base address is rejected
  // explicitly since the subtraction would otherwise wrap.
  assign offset    = addr_q - BASE_ADDR;
  assign word_off  = offset >> 3;
  assign in_range  = (addr_q >= BASE_ADDR) && (word_off[63:IDX_W] == '0);
  assign idx       = word_off[IDX_W-1:0];
  assign last_beat = (beat_q == len_q);

  assign aw_hs = aw_valid_i && aw_ready_o;
  assign ar_hs = ar_valid_i && ar_ready_o;
  assign w_hs  = w_valid_i  && w_ready_o;
  assign r_hs  = r_valid_o  && r_ready_i;

  // Handshake signals are held low while reset is asserted so no beat is
  // ever exchanged in a cycle the FSM is about to discard.
  always_comb begin
    state_d    = state_q;
    aw_ready_o = 1'b0;
    ar_ready_o = 1'b0;
    w_ready_o  = 1'b0;
    b_valid_o  = 1'b0;
    r_valid_o  = 1'b0;
    if (!rst_i) begin
      unique case (state_q)
        IDLE: begin
          aw_ready_o = 1'b1;
          ar_ready_o = !aw_valid_i;
          if (aw_valid_i)      state_d = WDATA;
          else if (ar_valid_i) state_d = READ;
        end
        READ: begin
          r_valid_o = 1'b1;
          if (r_ready_i && last_beat) state_d = IDLE;
        end
        WDATA: begin
          w_ready_o = 1'b1;
          if (w_valid_i && (w_last_i || last_beat)) state_d = WRESP;
        end
        WRESP: begin
          b_valid_o = 1'b1;
          if (b_ready_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign r_data_o = (r_valid_o && in_range) ? mem[idx] : 64'd0;
  assign r_resp_o = (r_valid_o && !in_range) ? RESP_SLVERR : RESP_OKAY;
  assign r_last_o = r_valid_o && last_beat;
  assign r_id_o   = id_q;
  assign b_resp_o = (b_valid_o && err_q) ? RESP_SLVERR : RESP_OKAY;
  assign b_id_o   = id_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (aw_hs) begin
            addr_q <= aw_addr_i;
            len_q  <= aw_len_i;
            id_q   <= aw_id_i;
            beat_q <= '0;
            err_q  <= 1'b0;
          end else if (ar_hs) begin
            addr_q <= ar_addr_i;
            len_q  <= ar_len_i;
            id_q   <= ar_id_i;
            beat_q <= '0;
          end
        end
        READ: begin
          if (r_hs) begin
            addr_q <= addr_q + 64'd8;
            beat_q <= beat_q + 8'd1;
          end
        end
        WDATA: begin
          if (w_hs) begin
            addr_q <= addr_q + 64'd8;
            beat_q <= beat_q + 8'd1;
            if (!in_range) err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk_i) begin
    if (w_hs && in_range) begin
      for (int b = 0; b < 8; b++) begin
        if (w_strb_i[b]) mem[idx][8*b +: 8] <= w_data_i[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dcache_refill_responder.sv
// Directed bench for dcache_refill_responder: bursts driven and checked on the
// falling clock edge against hand-computed expected beats.
module tb_dcache_refill_responder;

  logic        clk;
  logic        rst;
  logic        aw_valid, aw_ready;
  logic [63:0] aw_addr;
  logic [7:0]  aw_len;
  logic [3:0]  aw_id;
  logic        w_valid, w_ready;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        w_last;
  logic        b_valid, b_ready;
  logic [1:0]  b_resp;
  logic [3:0]  b_id;
  logic        ar_valid, ar_ready;
  logic [63:0] ar_addr;
  logic [7:0]  ar_len;
  logic [3:0]  ar_id;
  logic        r_valid, r_ready;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;
  logic [3:0]  r_id;

  int tests = 0;
  int fails = 0;

  logic [63:0] wd [16];
  logic [7:0]  ws [16];
  logic [63:0] ed [16];
  logic [1:0]  er [16];

  dcache_refill_responder #(
    .BASE_ADDR(64'h8000_0000),
    .NUM_WORDS(1024),
    .ID_WIDTH (4)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_addr_i(aw_addr),
    .aw_len_i(aw_len), .aw_id_i(aw_id),
    .w_valid_i(w_valid), .w_ready_o(w_ready), .w_data_i(w_data),
    .w_strb_i(w_strb), .w_last_i(w_last),
    .b_valid_o(b_valid), .b_ready_i(b_ready), .b_resp_o(b_resp), .b_id_o(b_id),
    .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_addr_i(ar_addr),
    .ar_len_i(ar_len), .ar_id_i(ar_id),
    .r_valid_o(r_valid), .r_ready_i(r_ready), .r_data_o(r_data),
    .r_resp_o(r_resp), .r_last_o(r_last), .r_id_o(r_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic write_burst(input logic [63:0] addr, input logic [7:0] len,
                             input logic [3:0] id, input logic [1:0] exp_resp);
    int n;
    aw_valid = 1'b1; aw_addr = addr; aw_len = len; aw_id = id;
    #1;
    n = 0;
    while (!aw_ready && n < 50) begin @(negedge clk); #1; n++; end
    if (n >= 50) check("aw_timeout", 64'(aw_ready), 64'd1);
    @(negedge clk);
    aw_valid = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      w_valid = 1'b1; w_data = wd[k]; w_strb = ws[k]; w_last = (k == int'(len));
      #1;
      if (k == 0) begin
        check("ready_in_wdata", {62'd0, aw_ready, ar_ready}, 64'd0);
      end
      n = 0;
      while (!w_ready && n < 50) begin @(negedge clk); #1; n++; end
      if (n >= 50) check("w_timeout", 64'(w_ready), 64'd1);
      @(negedge clk);
    end
    w_valid = 1'b0; w_last = 1'b0; b_ready = 1'b1;
    #1;
    n = 0;
    while (!b_valid && n < 50) begin @(negedge clk); #1; n++; end
    check("b_valid", 64'(b_valid), 64'd1);
    check("b_resp", 64'(b_resp), 64'(exp_resp));
    check("b_id", 64'(b_id), 64'(id));
    @(negedge clk);
    b_ready = 1'b0;
  endtask

  task automatic read_burst(input logic [63:0] addr, input logic [7:0] len,
                            input logic [3:0] id, input int stall_beat, input int rst_beat);
    int n;
    ar_valid = 1'b1; ar_addr = addr; ar_len = len; ar_id = id;
    #1;
    n = 0;
    while (!ar_ready && n < 50) begin @(negedge clk); #1; n++; end
    if (n >= 50) check("ar_timeout", 64'(ar_ready), 64'd1);
    @(negedge clk);
    ar_valid = 1'b0; r_ready = 1'b1;
    #1;
    check("r_first_valid", 64'(r_valid), 64'd1);
    for (int k = 0; k <= int'(len); k++) begin
      n = 0;
      while (!r_valid && n < 50) begin @(negedge clk); #1; n++; end
      if (k == rst_beat) begin
        r_ready = 1'b0; rst = 1'b1;
        @(negedge clk); #1;
        check("rst_r_valid", 64'(r_valid), 64'd0);
        check("rst_r_outs", {r_data[61:0], r_resp}, 64'd0);
        check("rst_r_last", 64'(r_last), 64'd0);
        rst = 1'b0;
        @(negedge clk); #1;
        check("post_rst_readies", {62'd0, aw_ready, ar_ready}, 64'd3);
        check("post_rst_idle", {57'd0, w_ready, b_valid, r_valid, r_id, 1'b0}, 64'd0);
        return;
      end
      check($sformatf("r_data[%0d]", k), r_data, ed[k]);
      check($sformatf("r_resp[%0d]", k), 64'(r_resp), 64'(er[k]));
      check($sformatf("r_last[%0d]", k), 64'(r_last), 64'(k == int'(len)));
      check($sformatf("r_id[%0d]", k), 64'(r_id), 64'(id));
      if (k == stall_beat) begin
        r_ready = 1'b0;
        repeat (5) begin
          @(negedge clk); #1;
          check("stall_valid", 64'(r_valid), 64'd1);
          check("stall_data", r_data, ed[k]);
          check("stall_resp_last", {61'd0, r_resp, r_last}, {61'd0, er[k], 1'b0});
        end
        r_ready = 1'b1;
      end
      @(negedge clk); #1;
    end
    check("r_done_idle", 64'(r_valid), 64'd0);
    r_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    aw_valid = 0; aw_addr = 0; aw_len = 0; aw_id = 0;
    w_valid = 0; w_data = 0; w_strb = 0; w_last = 0; b_ready = 0;
    ar_valid = 0; ar_addr = 0; ar_len = 0; ar_id = 0; r_ready = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_valids", {61'd0, w_ready, b_valid, r_valid}, 64'd0);
    check("rst_r_data", r_data, 64'd0);
    check("rst_resps_last", {59'd0, r_resp, b_resp, r_last}, 64'd0);
    check("rst_ids", {56'd0, r_id, b_id}, 64'd0);
    rst = 1'b0;
    @(negedge clk); #1;
    check("idle_readies", {62'd0, aw_ready, ar_ready}, 64'd3);

    // 8-beat writeback then refill of the same line
    for (int k = 0; k < 8; k++) begin wd[k] = 64'(k); ws[k] = 8'hFF; ed[k] = 64'(k); er[k] = 2'b00; end
    write_burst(64'h8000_0040, 8'd7, 4'd3, 2'b00);
    read_burst(64'h8000_0040, 8'd7, 4'd5, -1, -1);

    // Simultaneous AW and AR: write must win, read sees new data
    wd[0] = 64'hA5A5_A5A5_A5A5_A5A5; wd[1] = 64'h0123_4567_89AB_CDEF;
    ws[0] = 8'hFF; ws[1] = 8'hFF;
    ar_valid = 1'b1; ar_addr = 64'h8000_0100; ar_len = 8'd1; ar_id = 4'd2;
    aw_valid = 1'b1; aw_addr = 64'h8000_0100; aw_len = 8'd1; aw_id = 4'd1;
    #1;
    check("both_valid_readies", {62'd0, aw_ready, ar_ready}, 64'd2);
    write_burst(64'h8000_0100, 8'd1, 4'd1, 2'b00);
    ed[0] = wd[0]; ed[1] = wd[1]; er[0] = 2'b00; er[1] = 2'b00;
    read_burst(64'h8000_0100, 8'd1, 4'd2, -1, -1);

    // Partial strobe merge
    wd[0] = 64'h1122_3344_5566_7788; ws[0] = 8'hFF;
    write_burst(64'h8000_0200, 8'd0, 4'd4, 2'b00);
    wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'h0F;
    write_burst(64'h8000_0200, 8'd0, 4'd4, 2'b00);
    ed[0] = 64'h1122_3344_FFFF_FFFF; er[0] = 2'b00;
    read_burst(64'h8000_0200, 8'd0, 4'd9, -1, -1);

    // Top-of-memory and below-base accesses
    wd[0] = 64'hDEAD_0000_0000_0001; wd[1] = 64'hDEAD_0000_0000_0002;
    ws[0] = 8'hFF; ws[1] = 8'hFF;
    write_burst(64'h8000_1FF0, 8'd1, 4'd8, 2'b00);
    wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'hFF;
    write_burst(64'h7FFF_FFF8, 8'd0, 4'd10, 2'b10);
    ed[0] = 64'hDEAD_0000_0000_0001; ed[1] = 64'hDEAD_0000_0000_0002;
    ed[2] = 64'd0; ed[3] = 64'd0;
    er[0] = 2'b00; er[1] = 2'b00; er[2] = 2'b10; er[3] = 2'b10;
    read_burst(64'h8000_1FF0, 8'd3, 4'd11, -1, -1);

    // Back-pressure on beat 2
    for (int k = 0; k < 8; k++) begin ed[k] = 64'(k); er[k] = 2'b00; end
    read_burst(64'h8000_0040, 8'd7, 4'd6, 2, -1);

    // Reset in the middle of a read, memory must survive
    read_burst(64'h8000_0040, 8'd7, 4'd7, -1, 3);
    ed[0] = 64'd5; er[0] = 2'b00;
    read_burst(64'h8000_0068, 8'd0, 4'd12, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
